// File: rtl/perf_counter_ctrl.sv
// Performance counter block: per-source pending accumulators feeding a
// round-robin arbiter, one shared incrementer, and a read/clear handshake.
module perf_counter_ctrl #(
    parameter int NUM_CNT = 4,
    parameter int WIDTH   = 32,
    parameter int PEND_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CNT-1:0]         events,
    input  logic                       flush,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [$clog2(NUM_CNT)-1:0] mem_address,
    output logic [WIDTH-1:0]           mem_rdata,
    output logic                       mem_resp,
    output logic [NUM_CNT-1:0]         pend_ovf
);

    localparam int AW = $clog2(NUM_CNT);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RESP = 1'b1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [WIDTH-1:0]   cnt_q  [NUM_CNT];
    logic [WIDTH-1:0]   cnt_d  [NUM_CNT];
    logic [PEND_W-1:0]  pend_q [NUM_CNT];
    logic [PEND_W-1:0]  pend_d [NUM_CNT];
    logic [NUM_CNT-1:0] ovf_q, ovf_d;
    logic [AW-1:0]      rr_q, rr_d;
    logic [0:0]         state_q, state_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;

    logic               svc_vld;
    logic [AW-1:0]      svc_idx;
    logic [AW-1:0]      scan_idx;
    logic [WIDTH-1:0]   inc_val;
    logic               serv;

    // Round-robin pick: lowest offset from rr_q with pending work wins
    always_comb begin
        svc_vld  = 1'b0;
        svc_idx  = rr_q;
        scan_idx = rr_q;
        for (int j = NUM_CNT - 1; j >= 0; j--) begin
            scan_idx = rr_q + AW'(j);
            if (pend_q[scan_idx] != '0) begin
                svc_vld = 1'b1;
                svc_idx = scan_idx;
            end
        end
        inc_val = cnt_q[svc_idx] + WIDTH'(1);
    end

    // Counter, pending and overflow next-state; clear then flush override
    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_d[i]  = cnt_q[i];
            pend_d[i] = pend_q[i];
        end
        ovf_d = ovf_q;
        rr_d  = rr_q;
        serv  = 1'b0;
        if (svc_vld) begin
            cnt_d[svc_idx] = inc_val;
            rr_d           = svc_idx + AW'(1);
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            serv = svc_vld && (svc_idx == AW'(i));
            if (events[i] && !serv) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PEND_W'(1);
                end
            end else if (!events[i] && serv) begin
                pend_d[i] = pend_q[i] - PEND_W'(1);
            end
        end
        if (state_q == IDLE && mem_write) begin
            cnt_d[mem_address]  = '0;
            pend_d[mem_address] = '0;
            ovf_d[mem_address]  = 1'b0;
        end
        if (flush) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_d[i]  = '0;
                pend_d[i] = '0;
            end
            ovf_d = '0;
            rr_d  = '0;
        end
    end

    // Handshake FSM; read data is the pre-update counter value
    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (mem_write || mem_read) begin
                    state_d = RESP;
                    if (!mem_write) begin
                        rdata_d = cnt_q[mem_address];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= '0;
                pend_q[i] <= '0;
            end
            ovf_q   <= '0;
            rr_q    <= '0;
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                cnt_q[i]  <= cnt_d[i];
                pend_q[i] <= pend_d[i];
            end
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_resp  = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign pend_ovf  = ovf_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Scoreboard bench for perf_counter_ctrl: directed vectors, expected
// responses queued at issue and checked by independent monitors.
module tb_perf_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ev;
    logic        flush;
    logic        mem_read, mem_write;
    logic [1:0]  addr;
    logic [31:0] rdata;
    logic        resp;
    logic [3:0]  ovf;

    logic [3:0]  ev2;
    logic        rd2, wr2;
    logic [1:0]  addr2;
    logic [7:0]  rdata2;
    logic        resp2;
    logic [3:0]  ovf2;

    int checks = 0;
    int errors = 0;
    logic [31:0] q1[$];
    logic [7:0]  q2[$];
    logic [31:0] e1;
    logic [7:0]  e2;

    perf_counter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .events(ev), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(addr), .mem_rdata(rdata),
        .mem_resp(resp), .pend_ovf(ovf)
    );

    perf_counter_ctrl #(.NUM_CNT(4), .WIDTH(8), .PEND_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .events(ev2), .flush(flush),
        .mem_read(rd2), .mem_write(wr2),
        .mem_address(addr2), .mem_rdata(rdata2),
        .mem_resp(resp2), .pend_ovf(ovf2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor for the 32-bit instance
    always begin
        @(posedge clk);
        #1;
        if (resp) begin
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got rdata %h", rdata);
            end else begin
                e1 = q1.pop_front();
                chk("resp_rdata", rdata, e1);
            end
        end
    end

    // Monitor for the 8-bit instance
    always begin
        @(posedge clk);
        #1;
        if (resp2) begin
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp8 got rdata %h", rdata2);
            end else begin
                e2 = q2.pop_front();
                chk("resp8_rdata", {24'h0, rdata2}, {24'h0, e2});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        mem_read = 1'b1;
        addr     = a;
        q1.push_back(exp);
        @(negedge clk);
        mem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd8(input logic [1:0] a, input logic [7:0] exp);
        rd2   = 1'b1;
        addr2 = a;
        q2.push_back(exp);
        @(negedge clk);
        rd2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd_all(input logic [31:0] c0, input logic [31:0] c1,
                          input logic [31:0] c2, input logic [31:0] c3);
        rd(2'd0, c0);
        rd(2'd1, c1);
        rd(2'd2, c2);
        rd(2'd3, c3);
    endtask

    initial begin
        rst_n = 1'b0; ev = '0; flush = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; addr = '0;
        ev2 = '0; rd2 = 1'b0; wr2 = 1'b0; addr2 = '0;
        #12;
        chk("reset_resp", {31'h0, resp}, 32'h0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ovf", {28'h0, ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        rd_all(0, 0, 0, 0);

        // five single-source pulses
        ev = 4'b0001;
        cyc(5);
        ev = '0;
        cyc(6);
        rd(2'd0, 32'd5);
        chk("single_ovf", {28'h0, ovf}, 32'h0);

        // read in the flush cycle sees the pre-flush value
        mem_read = 1'b1; addr = 2'd0; flush = 1'b1;
        q1.push_back(32'd5);
        @(negedge clk);
        mem_read = 1'b0; flush = 1'b0;
        @(negedge clk);
        rd(2'd0, 32'd0);

        // contention: all sources for three cycles
        ev = 4'b1111;
        cyc(3);
        ev = '0;
        cyc(14);
        rd_all(3, 3, 3, 3);

        // clear idx1 while event[1] fires and pending[1] is 3
        ev = 4'b1111;
        cyc(4);
        mem_write = 1'b1; addr = 2'd1;
        q1.push_back(32'd0);
        @(negedge clk);
        mem_write = 1'b0; ev = '0;
        cyc(20);
        rd_all(8, 0, 8, 8);
        chk("clear_ovf", {28'h0, ovf}, 32'h0);

        // saturation: all sources held 40 cycles after a flush
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ev = 4'b1111;
        cyc(40);
        ev = '0;
        chk("sat_ovf", {28'h0, ovf}, 32'hF);
        cyc(70);
        rd_all(25, 25, 25, 24);

        // reset while the response is being presented
        mem_read = 1'b1; addr = 2'd0;
        q1.push_back(32'd25);
        @(negedge clk);
        mem_read = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_resp", {31'h0, resp}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ovf", {28'h0, ovf}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        rd_all(0, 0, 0, 0);

        // wrap on the 8-bit instance
        ev2 = 4'b0100;
        cyc(255);
        ev2 = '0;
        cyc(3);
        rd8(2'd2, 8'hFF);
        ev2 = 4'b0100;
        cyc(1);
        ev2 = '0;
        cyc(3);
        rd8(2'd2, 8'h00);
        chk("wrap_ovf", {28'h0, ovf2}, 32'h0);

        for (int k = 0; k < 20; k++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            @(negedge clk);
        end
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL resp_timeout got %0d pending expected 0",
                     q1.size() + q2.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/perf_counter_ctrl.md
PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter NUM_CNT, default 4: number of event sources and counters (power of two, 2..8).
REQ-002 Parameter WIDTH, default 32: counter width in bits.
REQ-003 Parameter PEND_W, default 4: width of each per-source pending-event accumulator.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 event  input  NUM_CNT  per-source single-cycle event strobes, sampled every cycle.
REQ-007 flush  input  1  synchronous clear of all counters, pending counts and overflow flags.
REQ-008 mem_read  input  1  read request for counter selected by mem_address.
REQ-009 mem_write  input  1  clear request for counter selected by mem_address.
REQ-010 mem_address  input  log2(NUM_CNT)  counter index.
REQ-011 mem_rdata  output  WIDTH  read data, valid only while mem_resp=1, else 0.
REQ-012 mem_resp  output  1  one-cycle completion strobe for a read or clear.
REQ-013 pend_ovf  output  NUM_CNT  sticky per-source flag: an event was lost to pending saturation.

Function
REQ-014 The block SHALL own NUM_CNT WIDTH-bit counters, updated only by a single shared +1 incrementer.
REQ-015 Each cycle, pending[i] SHALL increase by 1 when event[i]=1 and decrease by 1 when source i is serviced.
REQ-016 Event and service on the same index in the same cycle SHALL leave pending[i] unchanged.
REQ-017 pending[i] SHALL saturate at 2^PEND_W-1; an unserviced event at saturation SHALL be dropped and set pend_ovf[i].
REQ-018 Each cycle the arbiter SHALL service at most one index: the first i with pending[i]>0, searching round-robin from rr_ptr.
REQ-019 After servicing index k, rr_ptr SHALL become (k+1) mod NUM_CNT; with no service, rr_ptr SHALL hold.
REQ-020 Servicing index k SHALL increment counter[k] by 1 modulo 2^WIDTH (all-ones wraps to 0, no flag).
REQ-021 The counter value SHALL depend on pending[] registered state only; a same-cycle event SHALL be counted no earlier than the next cycle.
REQ-022 Handshake FSM states: IDLE, RESP.
REQ-023 IDLE with mem_read or mem_write sampled high SHALL go to RESP; mem_write has priority if both are high.
REQ-024 A read SHALL capture counter[mem_address] as of the request cycle (before that cycle's service), presented on mem_rdata in RESP.
REQ-025 A clear SHALL, at the end of the request cycle, zero counter[idx], pending[idx] and pend_ovf[idx], overriding any same-cycle service or event on idx.
REQ-026 RESP SHALL assert mem_resp for exactly one cycle and return to IDLE; requests in RESP SHALL be ignored.
REQ-027 Requesters SHALL deassert mem_read/mem_write in the cycle mem_resp=1; a held request is re-served every second cycle.
REQ-028 flush=1 SHALL zero all counters, pending, pend_ovf and rr_ptr at the edge, overriding service, events and clear; the FSM SHALL still progress normally.
REQ-029 A read issued in the flush cycle SHALL return the pre-flush value.

Reset
REQ-030 rst_n=0 SHALL immediately zero all counters, pending, pend_ovf, rr_ptr, mem_rdata and mem_resp, and force IDLE.
REQ-031 Reset during RESP SHALL abort the response; no mem_resp SHALL follow deassertion.
REQ-032 The first active edge after rst_n rises SHALL behave as a normal IDLE cycle.

Verification
REQ-033 Single source: event[0] pulsed 5 consecutive cycles -> counter[0]=5 within 6 cycles of the last pulse; pend_ovf=0.
REQ-034 Contention: event=4'b1111 held 3 cycles, then 0 -> after 12 more cycles every counter=3, services in order 0,1,2,3 repeating.
REQ-035 Saturation (PEND_W=4, NUM_CNT=4): event=4'b1111 held 40 cycles -> pend_ovf=4'b1111, each counter below 40, sum of counters plus final pending counts below 160.
REQ-036 Wrap: preload counter[2] to 0xFFFFFFFF via 2^32-1 force/backdoor, one event[2] -> read returns 0x00000000, pend_ovf[2]=0.
REQ-037 Clear vs event: mem_write idx1 in the same cycle as event[1] with pending[1]=3 -> next cycle mem_resp=1, counter[1]=0, pending[1]=0.
REQ-038 Reset mid-op: rst_n low during RESP with counters nonzero -> mem_resp=0 immediately, all counters read 0 after release.
